// File: rtl/conv_ctrl_gen.sv
// ============================================================================
// conv_ctrl_gen : parametrised valid-padding 2-D convolution sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module conv_ctrl_gen #(
  parameter int                ADDR_W   = 16,
  parameter int                DIM_W    = 8,
  parameter int                K        = 3,
  parameter logic [ADDR_W-1:0] SRC_BASE = 16'h0000,
  parameter logic [ADDR_W-1:0] W_BASE   = 16'h4000,
  parameter logic [ADDR_W-1:0] B_BASE   = 16'h8000,
  parameter logic [ADDR_W-1:0] DST_BASE = 16'hC000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_ctrl,
  input  logic [DIM_W-1:0]  in_w,
  input  logic [DIM_W-1:0]  in_h,
  input  logic [DIM_W-1:0]  in_ch,
  input  logic [DIM_W-1:0]  out_ch,
  input  logic [1:0]        stride,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [ADDR_W-1:0] save_addr,
  output logic              en_read,
  output logic              acc_clr,
  output logic              en_mac,
  output logic              en_sum,
  output logic              en_save,
  output logic              en_write,
  output logic              finish,
  output logic              err
);

  localparam int                KW     = (K > 1) ? $clog2(K) : 1;
  localparam logic [KW-1:0]     K_LAST = KW'(K - 1);
  localparam logic [DIM_W-1:0]  K_D    = DIM_W'(K);
  localparam logic [ADDR_W-1:0] K_A    = ADDR_W'(K);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_SUM   = 3'd4,
    S_SAVE  = 3'd5,
    S_WRITE = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t state_q, state_d;

  logic [DIM_W-1:0]  in_w_q, in_w_d;
  logic [DIM_W-1:0]  in_h_q, in_h_d;
  logic [DIM_W-1:0]  in_ch_q, in_ch_d;
  logic [DIM_W-1:0]  out_ch_q, out_ch_d;
  logic [1:0]        stride_q, stride_d;
  logic [DIM_W-1:0]  out_w_q, out_w_d;
  logic [DIM_W-1:0]  out_h_q, out_h_d;
  logic [DIM_W-1:0]  f_q, f_d;
  logic [DIM_W-1:0]  oy_q, oy_d;
  logic [DIM_W-1:0]  ox_q, ox_d;
  logic [DIM_W-1:0]  c_q, c_d;
  logic [KW-1:0]     ky_q, ky_d;
  logic [KW-1:0]     kx_q, kx_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic              err_q, err_d;
  logic              mac_q, mac_d;

  logic              cfg_bad;
  logic [ADDR_W-1:0] s_raw;
  logic [ADDR_W-1:0] w_raw;

  // Stride is 1..3, so the divide collapses to a shift or a constant divide.
  function automatic logic [DIM_W-1:0] div_stride(input logic [DIM_W-1:0] v,
                                                  input logic [1:0]       s);
    case (s)
      2'd2:    return v >> 1;
      2'd3:    return v / DIM_W'(3);
      default: return v;
    endcase
  endfunction

  assign cfg_bad = (in_w < K_D) | (in_h < K_D) | (in_ch == '0) |
                   (out_ch == '0) | (stride == 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      in_w_q    <= '0;
      in_h_q    <= '0;
      in_ch_q   <= '0;
      out_ch_q  <= '0;
      stride_q  <= '0;
      out_w_q   <= '0;
      out_h_q   <= '0;
      f_q       <= '0;
      oy_q      <= '0;
      ox_q      <= '0;
      c_q       <= '0;
      ky_q      <= '0;
      kx_q      <= '0;
      out_idx_q <= '0;
      err_q     <= 1'b0;
      mac_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_w_q    <= in_w_d;
      in_h_q    <= in_h_d;
      in_ch_q   <= in_ch_d;
      out_ch_q  <= out_ch_d;
      stride_q  <= stride_d;
      out_w_q   <= out_w_d;
      out_h_q   <= out_h_d;
      f_q       <= f_d;
      oy_q      <= oy_d;
      ox_q      <= ox_d;
      c_q       <= c_d;
      ky_q      <= ky_d;
      kx_q      <= kx_d;
      out_idx_q <= out_idx_d;
      err_q     <= err_d;
      mac_q     <= mac_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_w_d    = in_w_q;
    in_h_d    = in_h_q;
    in_ch_d   = in_ch_q;
    out_ch_d  = out_ch_q;
    stride_d  = stride_q;
    out_w_d   = out_w_q;
    out_h_d   = out_h_q;
    f_d       = f_q;
    oy_d      = oy_q;
    ox_d      = ox_q;
    c_d       = c_q;
    ky_d      = ky_q;
    kx_d      = kx_q;
    out_idx_d = out_idx_q;
    err_d     = err_q;
    mac_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en_ctrl) state_d = S_LOAD;
      end

      S_LOAD: begin
        in_w_d    = in_w;
        in_h_d    = in_h;
        in_ch_d   = in_ch;
        out_ch_d  = out_ch;
        stride_d  = stride;
        out_w_d   = div_stride(in_w - K_D, stride) + 1'b1;
        out_h_d   = div_stride(in_h - K_D, stride) + 1'b1;
        f_d       = '0;
        oy_d      = '0;
        ox_d      = '0;
        c_d       = '0;
        ky_d      = '0;
        kx_d      = '0;
        out_idx_d = '0;
        err_d     = cfg_bad;
        state_d   = cfg_bad ? S_DONE : S_READ;
      end

      S_READ: begin
        if (mem_ready) begin
          mac_d = 1'b1;
          if (kx_q != K_LAST) begin
            kx_d = kx_q + 1'b1;
          end else begin
            kx_d = '0;
            if (ky_q != K_LAST) begin
              ky_d = ky_q + 1'b1;
            end else begin
              ky_d = '0;
              if (c_q != in_ch_q - 1'b1) begin
                c_d = c_q + 1'b1;
              end else begin
                c_d     = '0;
                state_d = S_DRAIN;
              end
            end
          end
        end
      end

      S_DRAIN: state_d = S_SUM;
      S_SUM:   state_d = S_SAVE;
      S_SAVE:  state_d = S_WRITE;

      // Pixel order is f, oy, ox with ox fastest.
      S_WRITE: begin
        if (mem_ready) begin
          out_idx_d = out_idx_q + 1'b1;
          state_d   = S_READ;
          if (ox_q != out_w_q - 1'b1) begin
            ox_d = ox_q + 1'b1;
          end else begin
            ox_d = '0;
            if (oy_q != out_h_q - 1'b1) begin
              oy_d = oy_q + 1'b1;
            end else begin
              oy_d = '0;
              if (f_q != out_ch_q - 1'b1) begin
                f_d = f_q + 1'b1;
              end else begin
                f_d     = '0;
                state_d = S_DONE;
              end
            end
          end
        end
      end

      S_DONE: begin
        if (!en_ctrl) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_raw = SRC_BASE
          + ((ADDR_W'(c_q) * ADDR_W'(in_h_q)
              + ADDR_W'(oy_q) * ADDR_W'(stride_q)
              + ADDR_W'(ky_q)) * ADDR_W'(in_w_q))
          + ADDR_W'(ox_q) * ADDR_W'(stride_q)
          + ADDR_W'(kx_q);
    w_raw = W_BASE
          + ((ADDR_W'(f_q) * ADDR_W'(in_ch_q) + ADDR_W'(c_q)) * K_A
             + ADDR_W'(ky_q)) * K_A
          + ADDR_W'(kx_q);
  end

  // Addresses are forced to zero outside their strobe so idle outputs stay quiet.
  assign en_read   = (state_q == S_READ);
  assign acc_clr   = en_read && (c_q == '0) && (ky_q == '0) && (kx_q == '0);
  assign s_addr    = en_read ? s_raw : '0;
  assign w_addr    = en_read ? w_raw : '0;
  assign en_mac    = mac_q;
  assign en_sum    = (state_q == S_SUM);
  assign b_addr    = en_sum ? (B_BASE + ADDR_W'(f_q)) : '0;
  assign en_save   = (state_q == S_SAVE);
  assign en_write  = (state_q == S_WRITE);
  assign save_addr = en_write ? (DST_BASE + out_idx_q) : '0;
  assign finish    = (state_q == S_DONE);
  assign err       = finish && err_q;

endmodule

`default_nettype wire
